// File: rtl/unidad_ejecucion.sv
// Multi-cycle execute/write-back controller for the MicroUAZ 8-bit datapath.
// Drives the register bank's SelR/RW/DW and runs one ALU op or shift-add multiply per Start.
module unidad_ejecucion #(
  parameter bit MUL_EN = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic [3:0] Op,
  input  logic [2:0] Dst,
  input  logic [2:0] Src,
  input  logic [7:0] Imm,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] Flags,
  output logic [5:0] SelR,
  output logic       RW,
  output logic [7:0] DW,
  input  logic [7:0] Rx,
  input  logic [7:0] Ry
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PROD_W = 16;
  localparam logic [3:0]  OP_MUL      = 4'hA;
  localparam logic [3:0]  OP_LAST_ALU = 4'h9;

  typedef enum logic [2:0] {
    IDLE, EXEC, MUL_LOAD, MUL_ITER, MUL_WLO, MUL_WHI, DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        op_l;
  logic [2:0]        dst_l, src_l;
  logic [DATA_W-1:0] imm_l;
  logic [DATA_W-1:0] a_q, b_q;
  logic [PROD_W-1:0] p_q;
  logic [2:0]        cnt_q;

  logic              busy_d, done_d, rw_d;
  logic [5:0]        selr_d;
  logic [2:0]        flags_d;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_wr;
  logic [PROD_W-1:0] mul_add;

  // ALU on the bank's live read ports; Rx = Rd, Ry = Rs during EXEC
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_wr  = 1'b1;
    case (op_l)
      4'h0: alu_res = Ry;
      4'h1: alu_res = imm_l;
      4'h2: {alu_c, alu_res} = (DATA_W+1)'(Rx) + (DATA_W+1)'(Ry);
      4'h3: begin
        alu_res = Rx - Ry;
        alu_c   = (Rx < Ry);
      end
      4'h4: alu_res = Rx & Ry;
      4'h5: alu_res = Rx | Ry;
      4'h6: alu_res = Rx ^ Ry;
      4'h7: alu_res = ~Rx;
      4'h8: begin
        alu_c   = Rx[7];
        alu_res = {Rx[6:0], 1'b0};
      end
      4'h9: begin
        alu_c   = Rx[0];
        alu_res = {1'b0, Rx[7:1]};
      end
      default: alu_wr = 1'b0;
    endcase
  end

  assign mul_add = b_q[cnt_q] ? (PROD_W'(a_q) << cnt_q) : '0;

  // Next state and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rw_d    = 1'b0;
    selr_d  = '0;
    flags_d = Flags;
    case (state_q)
      IDLE: begin
        if (Start) begin
          busy_d = 1'b1;
          selr_d = {Src, Dst};
          if (MUL_EN && (Op == OP_MUL)) begin
            state_d = MUL_LOAD;
          end else begin
            state_d = EXEC;
            rw_d    = (Op <= OP_LAST_ALU);
          end
        end
      end
      EXEC: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = DONE;
        if (alu_wr) flags_d = {alu_res[7], alu_c, (alu_res == '0)};
      end
      MUL_LOAD: begin
        busy_d  = 1'b1;
        selr_d  = {src_l, dst_l};
        state_d = MUL_ITER;
      end
      MUL_ITER: begin
        busy_d = 1'b1;
        selr_d = {src_l, dst_l};
        if (cnt_q == 3'd7) begin
          state_d = MUL_WLO;
          rw_d    = 1'b1;
        end
      end
      MUL_WLO: begin
        busy_d  = 1'b1;
        rw_d    = 1'b1;
        selr_d  = {src_l, 3'(dst_l + 3'd1)};
        state_d = MUL_WHI;
      end
      MUL_WHI: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = DONE;
        flags_d = {p_q[15], (p_q[15:8] != '0), (p_q == '0)};
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write data must follow the bank's combinational read in EXEC
  always_comb begin
    case (state_q)
      EXEC:    DW = alu_wr ? alu_res : '0;
      MUL_WLO: DW = p_q[7:0];
      MUL_WHI: DW = p_q[15:8];
      default: DW = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      RW      <= 1'b0;
      SelR    <= '0;
      Flags   <= '0;
      op_l    <= '0;
      dst_l   <= '0;
      src_l   <= '0;
      imm_l   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      Busy    <= busy_d;
      Done    <= done_d;
      RW      <= rw_d;
      SelR    <= selr_d;
      Flags   <= flags_d;
      if (state_q == IDLE && Start) begin
        op_l  <= Op;
        dst_l <= Dst;
        src_l <= Src;
        imm_l <= Imm;
      end
      // Operands captured once, so writing Rd+1 cannot disturb the multiply
      if (state_q == MUL_LOAD) begin
        a_q   <= Rx;
        b_q   <= Ry;
        p_q   <= '0;
        cnt_q <= '0;
      end else if (state_q == MUL_ITER) begin
        p_q   <= p_q + mul_add;
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_unidad_ejecucion.sv
// Scoreboard bench for unidad_ejecucion: bench-side register bank, directed ops with
// hand-computed results, and a MUL_EN=0 instance for the multiply-as-NOP case.
module tb_unidad_ejecucion;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Start, Start0;
  logic [3:0] Op;
  logic [2:0] Dst, Src;
  logic [7:0] Imm;

  logic       Busy, Done, RW;
  logic [2:0] Flags;
  logic [5:0] SelR;
  logic [7:0] DW, Rx, Ry;

  logic       Busy0, Done0, RW0;
  logic [2:0] Flags0;
  logic [5:0] SelR0;
  logic [7:0] DW0, Rx0, Ry0;

  logic [7:0] rgs  [8] = '{default: 8'h00};
  logic [7:0] rgs0 [8] = '{0: 8'h12, 1: 8'h34, default: 8'h00};

  always #5 Clk = ~Clk;

  unidad_ejecucion #(.MUL_EN(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .Dst(Dst), .Src(Src), .Imm(Imm),
    .Busy(Busy), .Done(Done), .Flags(Flags), .SelR(SelR), .RW(RW), .DW(DW),
    .Rx(Rx), .Ry(Ry)
  );

  unidad_ejecucion #(.MUL_EN(1'b0)) dut0 (
    .Clk(Clk), .Rst(Rst), .Start(Start0), .Op(Op), .Dst(Dst), .Src(Src), .Imm(Imm),
    .Busy(Busy0), .Done(Done0), .Flags(Flags0), .SelR(SelR0), .RW(RW0), .DW(DW0),
    .Rx(Rx0), .Ry(Ry0)
  );

  // Register banks: combinational read, write on rising edge when RW
  assign Rx  = rgs[SelR[2:0]];
  assign Ry  = rgs[SelR[5:3]];
  assign Rx0 = rgs0[SelR0[2:0]];
  assign Ry0 = rgs0[SelR0[5:3]];
  always @(posedge Clk) if (RW)  rgs[SelR[2:0]]   <= DW;
  always @(posedge Clk) if (RW0) rgs0[SelR0[2:0]] <= DW0;

  typedef struct {
    string      nm;
    int         acc;
    int         lat;
    int         wr;
    logic [2:0] fl;
    logic [2:0] d;
    logic [7:0] v0;
    bit         two;
    logic [7:0] v1;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   wr_cnt = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per Done pulse
  exp_t       me;
  logic [2:0] hi;
  always @(negedge Clk) begin
    if (Rst) begin
      wr_cnt = 0;
    end else begin
      if (RW) wr_cnt++;
      if (Done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          me = sb.pop_front();
          chk({me.nm, ".latency"}, cyc - me.acc + 1, me.lat);
          chk({me.nm, ".writes"}, wr_cnt, me.wr);
          chk({me.nm, ".flags"}, int'(Flags), int'(me.fl));
          chk({me.nm, ".rd"}, int'(rgs[me.d]), int'(me.v0));
          if (me.two) begin
            hi = me.d + 3'd1;
            chk({me.nm, ".rd_hi"}, int'(rgs[hi]), int'(me.v1));
          end
        end
        wr_cnt = 0;
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s,
                      input logic [7:0] imm);
    @(negedge Clk);
    Start = 1'b1; Op = op; Dst = d; Src = s; Imm = imm;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic push(input string nm, input int lat, input int wr, input logic [2:0] fl,
                      input logic [2:0] d, input logic [7:0] v0, input logic [7:0] v1);
    exp_t e;
    e.nm = nm; e.acc = cyc; e.lat = lat; e.wr = wr; e.fl = fl;
    e.d = d; e.v0 = v0; e.two = (lat == 12); e.v1 = v1;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clk);
      got = Done;
    end
    if (!got) begin
      chk({nm, ".done_timeout"}, 0, 1);
      sb.delete();
    end
  endtask

  // Issue one op, record its expectation ({N,C,Z} flags), wait for completion
  task automatic run_op(input string nm, input logic [3:0] op, input logic [2:0] d,
                        input logic [2:0] s, input logic [7:0] imm, input logic [2:0] fl,
                        input logic [7:0] v0, input logic [7:0] v1);
    int lat = (op == 4'hA) ? 12 : 2;
    int wr  = (op == 4'hA) ? 2 : ((op <= 4'h9) ? 1 : 0);
    send(op, d, s, imm);
    push(nm, lat, wr, fl, d, v0, v1);
    wait_done(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rw_seen;
    int k;
    Rst = 1'b1; Start = 1'b0; Start0 = 1'b0;
    Op = '0; Dst = '0; Src = '0; Imm = '0;
    #1;
    chk("rst.busy",  int'(Busy),  0);
    chk("rst.done",  int'(Done),  0);
    chk("rst.flags", int'(Flags), 0);
    chk("rst.selr",  int'(SelR),  0);
    chk("rst.rw",    int'(RW),    0);
    chk("rst.dw",    int'(DW),    0);
    @(negedge Clk);
    Rst = 1'b0;

    run_op("ldi_r2",  4'h1, 3'd2, 3'd0, 8'hF0, 3'b100, 8'hF0, 8'h00);
    run_op("add_r2",  4'h2, 3'd2, 3'd2, 8'h00, 3'b110, 8'hE0, 8'h00);
    run_op("ldi_r7",  4'h1, 3'd7, 3'd0, 8'hFF, 3'b100, 8'hFF, 8'h00);
    run_op("ldi_r5",  4'h1, 3'd5, 3'd0, 8'hFF, 3'b100, 8'hFF, 8'h00);

    // Reset in cycle 5 of a multiply: outputs drop at once, no write afterwards
    send(4'hA, 3'd7, 3'd5, 8'h00);
    repeat (4) @(negedge Clk);
    #1 Rst = 1'b1;
    #1;
    chk("abort.busy",  int'(Busy),  0);
    chk("abort.rw",    int'(RW),    0);
    chk("abort.done",  int'(Done),  0);
    chk("abort.flags", int'(Flags), 0);
    @(negedge Clk);
    Rst = 1'b0;
    rw_seen = 0;
    repeat (14) begin
      @(negedge Clk);
      if (RW) rw_seen++;
    end
    chk("abort.no_write", rw_seen, 0);
    chk("abort.r7", int'(rgs[7]), 8'hFF);
    chk("abort.r0", int'(rgs[0]), 8'h00);

    run_op("mul_r7r5", 4'hA, 3'd7, 3'd5, 8'h00, 3'b110, 8'h01, 8'hFE);
    run_op("ldi_r1",   4'h1, 3'd1, 3'd0, 8'h05, 3'b000, 8'h05, 8'h00);
    run_op("ldi_r4",   4'h1, 3'd4, 3'd0, 8'h05, 3'b000, 8'h05, 8'h00);
    run_op("sub_zero", 4'h3, 3'd1, 3'd4, 8'h00, 3'b001, 8'h00, 8'h00);
    run_op("sub_neg",  4'h3, 3'd1, 3'd4, 8'h00, 3'b110, 8'hFB, 8'h00);
    run_op("mov_r3",   4'h0, 3'd3, 3'd7, 8'h00, 3'b000, 8'h01, 8'h00);
    run_op("xor_r3",   4'h6, 3'd3, 3'd2, 8'h00, 3'b100, 8'hE1, 8'h00);
    run_op("shr_r3",   4'h9, 3'd3, 3'd0, 8'h00, 3'b010, 8'h70, 8'h00);
    run_op("or_r1",    4'h5, 3'd1, 3'd3, 8'h00, 3'b100, 8'hFB, 8'h00);
    run_op("and_r1",   4'h4, 3'd1, 3'd4, 8'h00, 3'b000, 8'h01, 8'h00);
    run_op("shl_r2",   4'h8, 3'd2, 3'd0, 8'h00, 3'b110, 8'hC0, 8'h00);
    run_op("not_r3",   4'h7, 3'd3, 3'd0, 8'h00, 3'b100, 8'h8F, 8'h00);

    // NOP with Start held through EXEC and DONE: exactly one operation
    @(negedge Clk);
    Start = 1'b1; Op = 4'hC; Dst = 3'd3; Src = 3'd0; Imm = 8'h00;
    @(negedge Clk);
    push("nop_held", 2, 0, 3'b100, 3'd3, 8'h8F, 8'h00);
    chk("nop_held.busy", int'(Busy), 1);
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    chk("nop_held.single_op", sb.size(), 0);

    run_op("mul_wrap_src", 4'hA, 3'd3, 3'd4, 8'h00, 3'b010, 8'hCB, 8'h02);
    run_op("mul_zero",     4'hA, 3'd6, 3'd6, 8'h00, 3'b001, 8'h00, 8'h00);

    // MUL_EN=0 instance: opcode A behaves as a NOP
    @(negedge Clk);
    Start0 = 1'b1; Op = 4'hA; Dst = 3'd0; Src = 3'd1;
    @(negedge Clk);
    Start0 = 1'b0;
    chk("nomul.busy", int'(Busy0), 1);
    rw_seen = RW0 ? 1 : 0;
    k = 1;
    while (!Done0 && k < 20) begin
      @(negedge Clk);
      k++;
      if (RW0) rw_seen++;
    end
    chk("nomul.latency", k, 2);
    chk("nomul.writes",  rw_seen, 0);
    chk("nomul.r0",      int'(rgs0[0]), 8'h12);
    chk("nomul.r1",      int'(rgs0[1]), 8'h34);
    chk("nomul.flags",   int'(Flags0), 0);

    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
